// File: rtl/ac97_out_fifo_p.sv
// AC97 output-slot sample FIFO: DEPTH=2**AW words, threshold request, level, sticky ovf/udf.
// Optional macro AC97_OUT_FIFO_HOLD_EN: an underrun read repeats the last sample instead of silence.
module ac97_out_fifo_p #(
  parameter int AW = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [1:0]    mode_i,
  input  logic [31:0]   din_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW:0]   thr_i,
  input  logic          clr_i,
  output logic [19:0]   dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o,
  output logic          req_o,
  output logic          ovf_o,
  output logic          udf_o
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   level_q, level_d;
  logic          hs_q, hs_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic [19:0]   dout_q, dout_d;

  logic [31:0]   head;
  logic          full, empty, rd_ok, pop, wr_ok, ovf_evt, udf_evt;

  assign head    = mem_q[rp_q];
  assign full    = (level_q == DEPTH_W);
  assign empty   = (level_q == '0);
  assign rd_ok   = en_i & re_i & ~empty;
  // In packed 16-bit mode the head word is only popped after its upper half is delivered.
  assign pop     = rd_ok & ((mode_i != 2'b00) | hs_q);
  assign wr_ok   = en_i & we_i & (~full | pop);
  assign ovf_evt = en_i & we_i & full & ~pop;
  assign udf_evt = en_i & re_i & empty;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    hs_d    = hs_q;
    dout_d  = dout_q;
    ovf_d   = (ovf_q & ~clr_i) | ovf_evt;
    udf_d   = (udf_q & ~clr_i) | udf_evt;
    if (!en_i) begin
      wp_d    = '0;
      rp_d    = '0;
      level_d = '0;
      hs_d    = 1'b0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_ok) wp_d = wp_q + 1'b1;
      if (pop)   rp_d = rp_q + 1'b1;
      case ({wr_ok, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (rd_ok) begin
        case (mode_i)
          2'b00: begin
            dout_d = hs_q ? {head[31:16], 4'h0} : {head[15:0], 4'h0};
            hs_d   = ~hs_q;
          end
          2'b01:   dout_d = {head[17:0], 2'b00};
          default: dout_d = head[19:0];
        endcase
      end else if (udf_evt) begin
`ifdef AC97_OUT_FIFO_HOLD_EN
        dout_d = dout_q;
`else
        dout_d = 20'h0;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      hs_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      hs_q    <= hs_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      dout_q  <= dout_d;
    end
  end

  // Storage carries no reset; only the pointers and level define its contents.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wp_q] <= din_i;
  end

  assign dout_o  = dout_q;
  assign full_o  = full;
  assign empty_o = empty;
  assign level_o = level_q;
  assign req_o   = en_i & (level_q <= thr_i);
  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;

endmodule

// File: tb/tb_ac97_out_fifo_p.sv
// Directed bench for ac97_out_fifo_p (AW=3); underrun expectation follows AC97_OUT_FIFO_HOLD_EN.
module tb_ac97_out_fifo_p;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic [1:0]  mode_i;
  logic [31:0] din_i;
  logic        we_i;
  logic        re_i;
  logic [3:0]  thr_i;
  logic        clr_i;
  logic [19:0] dout_o;
  logic        full_o, empty_o, req_o, ovf_o, udf_o;
  logic [3:0]  level_o;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [19:0] exp_dout;

  ac97_out_fifo_p #(.AW(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .mode_i(mode_i), .din_i(din_i),
    .we_i(we_i), .re_i(re_i), .thr_i(thr_i), .clr_i(clr_i), .dout_o(dout_o),
    .full_o(full_o), .empty_o(empty_o), .level_o(level_o), .req_o(req_o),
    .ovf_o(ovf_o), .udf_o(udf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    we_i = 1'b1; din_i = d;
    tick();
    we_i = 1'b0;
  endtask

  task automatic rd();
    re_i = 1'b1;
    tick();
    re_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; en_i = 1'b0; mode_i = 2'b10; din_i = '0;
    we_i = 1'b0; re_i = 1'b0; thr_i = 4'd2; clr_i = 1'b0;
    tick(); tick();
    check("rst_dout", dout_o, 0);
    check("rst_level", level_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_udf", udf_o, 0);
    check("rst_req_en0", req_o, 0);
    rst_ni = 1'b1; en_i = 1'b1;
    #1;
    check("en_req", req_o, 1);

    // Mode 10: fill, overrun, drain in order
    for (int i = 0; i < 3; i++) wr(32'h1357_0000 + i * 32'h0001_1111);
    check("lvl3", level_o, 3);
    check("req_lvl3", req_o, 0);
    for (int i = 3; i < 8; i++) wr(32'h1357_0000 + i * 32'h0001_1111);
    check("full8", full_o, 1);
    check("lvl8", level_o, 8);
    check("ovf_before", ovf_o, 0);
    wr(32'hDEAD_BEEF);
    check("ovf_set", ovf_o, 1);
    check("lvl8_after_ovf", level_o, 8);
    for (int i = 0; i < 8; i++) begin
      rd();
      check($sformatf("m10_rd%0d", i), dout_o, (32'h1357_0000 + i * 32'h0001_1111) & 32'hF_FFFF);
    end
    check("m10_empty", empty_o, 1);
    check("m10_full0", full_o, 0);
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    check("ovf_clr", ovf_o, 0);

    // Mode 00: two halves of one word
    mode_i = 2'b00;
    wr(32'hABCD_1234);
    rd();
    check("m00_lo", dout_o, 20'h12340);
    check("m00_lvl1", level_o, 1);
    check("m00_notempty", empty_o, 0);
    rd();
    check("m00_hi", dout_o, 20'hABCD0);
    check("m00_lvl0", level_o, 0);
    check("m00_empty", empty_o, 1);

    // Mode 01: full FIFO with simultaneous write and read
    mode_i = 2'b01;
    wr(32'hFFF2_AAAB);
    for (int j = 1; j < 8; j++) wr(32'h0000_0100 + j);
    check("m01_full", full_o, 1);
    we_i = 1'b1; din_i = 32'h0001_5555; re_i = 1'b1;
    tick();
    we_i = 1'b0; re_i = 1'b0;
    check("m01_simul_dout", dout_o, 20'hAAAAC);
    check("m01_simul_lvl", level_o, 8);
    check("m01_simul_ovf", ovf_o, 0);
    for (int j = 1; j < 8; j++) begin
      rd();
      check($sformatf("m01_rd%0d", j), dout_o, 20'h00400 + 4 * j);
    end
    rd();
    check("m01_rd_new", dout_o, 20'h55554);
    check("m01_empty", empty_o, 1);

    // Underrun
    mode_i = 2'b10;
    wr(32'hFFF5_A5A5);
    rd();
    check("last_sample", dout_o, 20'h5A5A5);
    rd();
`ifdef AC97_OUT_FIFO_HOLD_EN
    exp_dout = 20'h5A5A5;
`else
    exp_dout = 20'h0;
`endif
    check("udf_set", udf_o, 1);
    check("udf_dout", dout_o, exp_dout);
    check("udf_lvl", level_o, 0);
    re_i = 1'b1; clr_i = 1'b1; tick(); re_i = 1'b0; clr_i = 1'b0;
    check("udf_event_wins", udf_o, 1);
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    check("udf_clr", udf_o, 0);

    // en=0 clears, dout held
    rd();
    check("udf_again", udf_o, 1);
    for (int i = 0; i < 5; i++) wr(32'h0000_7000 + i);
    check("lvl5", level_o, 5);
    en_i = 1'b0;
    #1;
    check("req_en0", req_o, 0);
    tick();
    en_i = 1'b1;
    #1;
    check("en0_lvl", level_o, 0);
    check("en0_empty", empty_o, 1);
    check("en0_ovf", ovf_o, 0);
    check("en0_udf", udf_o, 0);
    check("en0_dout", dout_o, exp_dout);

    // Wrap-around with back-to-back write+read
    wr(32'hABC3_0000);
    for (int i = 1; i < 20; i++) begin
      we_i = 1'b1; din_i = 32'hABC3_0000 + i; re_i = 1'b1;
      tick();
      check($sformatf("wrap_rd%0d", i - 1), dout_o, 20'h30000 + i - 1);
      check($sformatf("wrap_lvl%0d", i), level_o, 1);
    end
    we_i = 1'b0;
    tick();
    re_i = 1'b0;
    check("wrap_rd19", dout_o, 20'h30013);
    check("wrap_empty", empty_o, 1);

    // Asynchronous reset mid-cycle
    wr(32'h1111_1111);
    wr(32'h2222_2222);
    check("pre_arst_lvl", level_o, 2);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_lvl", level_o, 0);
    check("arst_empty", empty_o, 1);
    check("arst_dout", dout_o, 0);
    rst_ni = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
